// File: rtl/lcd_char_decoder.sv
// lcd_char_decoder: receive side of the 4-bit LCD character interface.
// Pairs a high and a low DATA nibble word into one ASCII character and
// decodes '0'-'9' / 'A'-'F' into a 4-bit hex value. Bad framing, command
// words arriving mid-pair and orphaned high nibbles are reported as errors.
//
// Handshakes:
//   word_in is accepted on a rising edge where word_valid & word_ready.
//   hex_out is offered while hex_valid=1. It stays stable until a rising
//   edge with hex_ready=1, after which hex_valid drops.
//   err_valid is a one-cycle pulse with no back-pressure. err_code
//   qualifies it.

module lcd_char_decoder #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] word_in,
    input  logic       word_valid,
    output logic       word_ready,
    output logic [3:0] hex_out,
    output logic       hex_valid,
    input  logic       hex_ready,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HIGH_HELD = 2'd1,
        ST_OUT_PEND  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_BAD_HIGH  = 2'd0,
        ERR_BAD_LOW   = 2'd1,
        ERR_TIMEOUT   = 2'd2,
        ERR_SYNC_LOST = 2'd3
    } err_t;

    // TIMEOUT_CYC == 0 disables the timeout entirely.
    localparam logic TIMEOUT_EN = (TIMEOUT_CYC != 0);
    // The counter holds the number of idle HIGH_HELD cycles already completed.
    // The cycle that would complete the TIMEOUT_CYC-th one is the expiry cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  high_q, high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  hex_q, hex_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        is_data;
    logic [3:0]  nib;
    logic        high_ok;
    logic        low_digit;
    logic        low_alpha;
    logic [3:0]  low_hex;
    logic        expire;
    logic        accept;
    logic        raise;
    err_t        raise_code;

    // Word classification and character decode of the current word against the held high nibble.
    always_comb begin
        nib       = word_in[3:0];
        // Only RS=1, MARK=0 is data. Every other combination counts as a command.
        is_data   = (word_in[5:4] == 2'b10);
        high_ok   = (nib == 4'd3) || (nib == 4'd4);
        low_digit = (high_q == 4'd3) && (nib <= 4'd9);
        low_alpha = (high_q == 4'd4) && (nib >= 4'd1) && (nib <= 4'd6);
        // 'A'..'F' arrive as low nibble 1..6. Adding 9 in 4 bits gives 0xA..0xF.
        low_hex   = low_alpha ? (nib + 4'd9) : nib;
    end

    // Expiry takes priority over a word, so the handshake is withheld on the expiry cycle.
    always_comb begin
        expire     = TIMEOUT_EN && (state_q == ST_HIGH_HELD) && (cnt_q == CNT_LAST);
        word_ready = rst_n && ((state_q == ST_IDLE) ||
                               ((state_q == ST_HIGH_HELD) && !expire));
        accept     = word_valid && word_ready;
    end

    // Next-state logic: character pairing, decode, timeout and error selection.
    always_comb begin
        state_d    = state_q;
        high_d     = high_q;
        cnt_d      = cnt_q;
        hex_d      = hex_q;
        raise      = 1'b0;
        raise_code = ERR_BAD_HIGH;

        case (state_q)
            ST_IDLE: begin
                // Command words in IDLE are silently dropped.
                if (accept && is_data) begin
                    if (high_ok) begin
                        high_d  = nib;
                        cnt_d   = '0;
                        state_d = ST_HIGH_HELD;
                    end else begin
                        raise      = 1'b1;
                        raise_code = ERR_BAD_HIGH;
                    end
                end
            end

            ST_HIGH_HELD: begin
                if (expire) begin
                    raise      = 1'b1;
                    raise_code = ERR_TIMEOUT;
                    high_d     = '0;
                    state_d    = ST_IDLE;
                end else if (accept) begin
                    high_d  = '0;
                    state_d = ST_IDLE;
                    if (!is_data) begin
                        // A command mid-pair means the nibble stream lost alignment.
                        raise      = 1'b1;
                        raise_code = ERR_SYNC_LOST;
                    end else if (low_digit || low_alpha) begin
                        hex_d   = low_hex;
                        state_d = ST_OUT_PEND;
                    end else begin
                        raise      = 1'b1;
                        raise_code = ERR_BAD_LOW;
                    end
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_OUT_PEND: begin
                if (hex_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                high_d  = '0;
            end
        endcase
    end

    // Error pulse, sticky code and saturating error count.
    always_comb begin
        err_valid_d = raise;
        err_code_d  = raise ? raise_code : err_code_q;
        err_cnt_d   = err_cnt_q;
        if (raise && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            high_q      <= '0;
            cnt_q       <= '0;
            hex_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            high_q      <= high_d;
            cnt_q       <= cnt_d;
            hex_q       <= hex_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign hex_out   = hex_q;
    assign hex_valid = (state_q == ST_OUT_PEND);
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lcd_char_decoder.sv
// Testbench for lcd_char_decoder with a short timeout.
// The model works in ASCII terms, so a character is high*16 + low.
// It tracks a pending high nibble, the idle cycles waited and whether a result is offered.
module tb_lcd_char_decoder;

    localparam int TO = 8;

    logic       clk;
    logic       rst_n;
    logic [5:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic [3:0] hex_out;
    logic       hex_valid;
    logic       hex_ready;
    logic       err_valid;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    int tests  = 0;
    int failed = 0;

    lcd_char_decoder #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .hex_out    (hex_out),
        .hex_valid  (hex_valid),
        .hex_ready  (hex_ready),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_cnt    (err_cnt)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    bit m_known = 0;
    int m_high  = -1;   // pending high nibble, -1 when none
    int m_wait  = 0;    // idle cycles spent holding the high nibble
    bit m_pend  = 0;    // character waiting for the consumer
    int m_hex   = 0;
    bit m_err_v = 0;
    int m_err_code = 0;
    int m_cnt   = 0;

    function automatic void m_raise(input int code);
        m_err_v    = 1;
        m_err_code = code;
        if (m_cnt < 255) m_cnt++;
    endfunction

    function automatic bit m_expiring();
        return (TO > 0) && (m_high >= 0) && (m_wait + 1 == TO);
    endfunction

    // Applies one rising edge, using the inputs that edge will sample.
    function automatic void m_step(input logic rst, input logic v, input logic [5:0] w, input logic hr);
        int ch;
        bit is_data;
        int nibv;
        if (!rst) begin
            m_known = 1; m_high = -1; m_wait = 0; m_pend = 0; m_hex = 0;
            m_err_v = 0; m_err_code = 0; m_cnt = 0;
            return;
        end
        m_err_v = 0;
        is_data = (w[5:4] == 2'b10);
        nibv    = int'(w[3:0]);
        if (m_pend) begin
            if (hr) m_pend = 0;
        end else if (m_expiring()) begin
            m_raise(2);
            m_high = -1;
        end else if (v) begin
            if (m_high < 0) begin
                if (is_data) begin
                    if (nibv == 3 || nibv == 4) begin
                        m_high = nibv;
                        m_wait = 0;
                    end else begin
                        m_raise(0);
                    end
                end
            end else if (!is_data) begin
                m_raise(3);
                m_high = -1;
            end else begin
                ch = m_high * 16 + nibv;
                if (ch >= 48 && ch <= 57) begin
                    m_hex = ch - 48; m_pend = 1;
                end else if (ch >= 65 && ch <= 70) begin
                    m_hex = ch - 55; m_pend = 1;
                end else begin
                    m_raise(1);
                end
                m_high = -1;
            end
        end else if (m_high >= 0) begin
            m_wait++;
        end
    endfunction

    // Scoreboard: compare every cycle, then advance the model for the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                check("word_ready", 16'(word_ready), 16'(rst_n && !m_pend && !m_expiring()));
                check("hex_valid", 16'(hex_valid), 16'(m_pend));
                if (m_pend) check("hex_out", 16'(hex_out), 16'(m_hex));
                check("err_valid", 16'(err_valid), 16'(m_err_v));
                if (m_err_v) check("err_code", 16'(err_code), 16'(m_err_code));
                check("err_cnt", 16'(err_cnt), 16'(m_cnt));
            end
            m_step(rst_n, word_valid, word_in, hex_ready);
        end
    end

    // Driver: presents one cycle of inputs, then returns shortly after the edge.
    task automatic cyc(input logic v, input logic [5:0] w, input logic hr);
        word_valid = v;
        word_in    = w;
        hex_ready  = hr;
        @(posedge clk);
        #3;
    endtask

    task automatic pair(input logic [5:0] hi, input logic [5:0] lo);
        cyc(1'b1, hi, 1'b1);
        cyc(1'b1, lo, 1'b1);
    endtask

    // Directed stimulus with literal expectations
    initial begin
        rst_n = 1'b0; word_valid = 1'b0; word_in = '0; hex_ready = 1'b1;
        cyc(1'b0, 6'h00, 1'b1);
        cyc(1'b0, 6'h00, 1'b1);
        check("rst word_ready", 16'(word_ready), 16'd0);
        check("rst hex_valid", 16'(hex_valid), 16'd0);
        check("rst hex_out", 16'(hex_out), 16'd0);
        check("rst err_code", 16'(err_code), 16'd0);
        check("rst err_cnt", 16'(err_cnt), 16'd0);
        rst_n = 1'b1;
        #1;
        check("ready after rst", 16'(word_ready), 16'd1);

        // '7' back-to-back
        pair(6'h23, 6'h27);
        check("7 valid", 16'(hex_valid), 16'd1);
        check("7 hex", 16'(hex_out), 16'h7);
        cyc(1'b0, 6'h00, 1'b1);
        check("7 done", 16'(hex_valid), 16'd0);
        check("7 err_cnt", 16'(err_cnt), 16'd0);

        // 'F' under backpressure
        cyc(1'b1, 6'h24, 1'b0);
        cyc(1'b1, 6'h26, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("F hold valid", 16'(hex_valid), 16'd1);
            check("F hold hex", 16'(hex_out), 16'hF);
            check("F hold ready", 16'(word_ready), 16'd0);
            cyc(1'b0, 6'h00, 1'b0);
        end
        cyc(1'b0, 6'h00, 1'b1);
        check("F released", 16'(hex_valid), 16'd0);
        check("F ready back", 16'(word_ready), 16'd1);

        // Boundary characters '9' and 'A', plus a silent idle command
        pair(6'h23, 6'h29);
        check("9 hex", 16'(hex_out), 16'h9);
        cyc(1'b1, 6'h05, 1'b1);
        check("idle cmd silent", 16'(err_valid), 16'd0);
        pair(6'h24, 6'h21);
        check("A hex", 16'(hex_out), 16'hA);
        cyc(1'b0, 6'h00, 1'b1);

        // Bad characters
        pair(6'h24, 6'h27);
        check("G err", 16'(err_valid), 16'd1);
        check("G code", 16'(err_code), 16'd1);
        pair(6'h24, 6'h20);
        check("@ code", 16'(err_code), 16'd1);
        cyc(1'b1, 6'h25, 1'b1);
        check("bad high code", 16'(err_code), 16'd0);
        cyc(1'b0, 6'h00, 1'b1);
        check("bad err_cnt", 16'(err_cnt), 16'd3);
        check("bad no hex", 16'(hex_valid), 16'd0);

        // Resync on a command mid-pair
        pair(6'h23, 6'h10);
        check("sync code", 16'(err_code), 16'd3);
        pair(6'h23, 6'h25);
        check("sync 5 valid", 16'(hex_valid), 16'd1);
        check("sync 5 hex", 16'(hex_out), 16'h5);
        cyc(1'b0, 6'h00, 1'b1);
        // RS=1, MARK=1 counts as a command
        pair(6'h23, 6'h33);
        check("odd class code", 16'(err_code), 16'd3);

        // Timeout
        cyc(1'b1, 6'h24, 1'b1);
        for (int i = 0; i < TO - 1; i++) cyc(1'b0, 6'h00, 1'b1);
        check("to pre err", 16'(err_valid), 16'd0);
        check("to expiry ready", 16'(word_ready), 16'd0);
        cyc(1'b0, 6'h00, 1'b1);
        check("to err", 16'(err_valid), 16'd1);
        check("to code", 16'(err_code), 16'd2);
        pair(6'h23, 6'h20);
        check("0 hex", 16'(hex_out), 16'h0);
        check("0 valid", 16'(hex_valid), 16'd1);
        cyc(1'b0, 6'h00, 1'b1);

        // Timeout with a word on the expiry cycle
        cyc(1'b1, 6'h24, 1'b1);
        for (int i = 0; i < TO - 1; i++) cyc(1'b0, 6'h00, 1'b1);
        cyc(1'b1, 6'h23, 1'b1);
        check("to2 code", 16'(err_code), 16'd2);
        check("to2 not taken", 16'(hex_valid), 16'd0);
        cyc(1'b0, 6'h00, 1'b1);
        check("to2 still idle", 16'(hex_valid), 16'd0);
        check("to2 err_cnt", 16'(err_cnt), 16'd7);

        // Reset mid-pair
        cyc(1'b1, 6'h23, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, 6'h00, 1'b1);
        rst_n = 1'b1;
        check("midrst cnt", 16'(err_cnt), 16'd0);
        cyc(1'b1, 6'h29, 1'b1);
        check("midrst err", 16'(err_valid), 16'd1);
        check("midrst code", 16'(err_code), 16'd0);
        check("midrst no hex", 16'(hex_valid), 16'd0);
        check("midrst cnt1", 16'(err_cnt), 16'd1);

        // Saturation of the error counter
        for (int i = 0; i < 260; i++) cyc(1'b1, 6'h25, 1'b1);
        cyc(1'b0, 6'h00, 1'b1);
        check("err_cnt sat", 16'(err_cnt), 16'd255);
        cyc(1'b0, 6'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
